// File: rtl/count_pkg.sv
// Shared types and default sizes for the count sequencer and its prescaler.
package count_pkg;

    localparam int COUNT_WIDTH      = 2;
    localparam int COUNT_PRESCALE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/count_prescaler.sv
// Divide-by-(divisor+1) step generator. It counts only while enabled and
// returns to zero whenever cleared, so each run starts from a fresh phase.
module count_prescaler
    import count_pkg::*;
#(
    parameter int PRESCALE_W = COUNT_PRESCALE_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  en,
    input  logic [PRESCALE_W-1:0] divisor,
    output logic                  step
);

    logic [PRESCALE_W-1:0] cnt;

    assign step = en && !clear && (cnt == divisor);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= step ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/count_sequencer.sv
// Sequences a WIDTH-bit up/down counter: load on start, prescaled stepping,
// stop-or-wrap at the terminal count, terminal events over valid/ready.
module count_sequencer
    import count_pkg::*;
#(
    parameter int WIDTH      = COUNT_WIDTH,
    parameter int PRESCALE_W = COUNT_PRESCALE_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic [WIDTH-1:0]      load_val,
    input  logic [WIDTH-1:0]      limit,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  dir_down,
    input  logic                  mode_wrap,
    output logic [WIDTH-1:0]      count,
    output logic                  busy,
    output logic                  done,
    output logic                  evt_valid,
    input  logic                  evt_ready,
    output logic                  overrun
);

    // Event handshake: evt_valid is raised by a terminal step and held until
    // a cycle with evt_valid & evt_ready; a terminal that arrives while the
    // previous event is still held and not accepted in that cycle is lost and
    // recorded in overrun.

    state_t                state;
    logic [WIDTH-1:0]      load_sh;
    logic [WIDTH-1:0]      limit_sh;
    logic [PRESCALE_W-1:0] prescale_sh;
    logic                  dir_sh;
    logic                  wrap_sh;
    logic                  step;
    logic [WIDTH-1:0]      next_count;
    logic                  terminal;

    count_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
        .clk     (clk),
        .reset   (reset),
        .clear   (state != ST_RUN),
        .en      (state == ST_RUN),
        .divisor (prescale_sh),
        .step    (step)
    );

    assign next_count = dir_sh ? count - 1'b1 : count + 1'b1;
    assign terminal   = step && (next_count == limit_sh);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            count       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            evt_valid   <= 1'b0;
            overrun     <= 1'b0;
            load_sh     <= '0;
            limit_sh    <= '0;
            prescale_sh <= '0;
            dir_sh      <= 1'b0;
            wrap_sh     <= 1'b0;
        end else begin
            if (evt_valid && evt_ready) begin
                evt_valid <= 1'b0;
            end
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (stop) begin
                        state <= ST_IDLE;
                        done  <= 1'b0;
                    end else if (start) begin
                        state       <= ST_RUN;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        count       <= load_val;
                        load_sh     <= load_val;
                        limit_sh    <= limit;
                        prescale_sh <= prescale;
                        dir_sh      <= dir_down;
                        wrap_sh     <= mode_wrap;
                        overrun     <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // stop outranks a step landing on the same edge
                    if (stop) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (terminal) begin
                        evt_valid <= 1'b1;
                        if (evt_valid && !evt_ready) begin
                            overrun <= 1'b1;
                        end
                        if (wrap_sh) begin
                            count <= load_sh;
                        end else begin
                            count <= limit_sh;
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else if (step) begin
                        count <= next_count;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_count_sequencer.sv
// Self-checking bench for count_sequencer: directed scenarios plus a random
// run, all checked against a cycle-countdown reference model.
module tb_count_sequencer;
    import count_pkg::*;

    localparam int WIDTH      = 2;
    localparam int PRESCALE_W = 4;
    localparam int M          = 1 << WIDTH;

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic                  start = 1'b0;
    logic                  stop = 1'b0;
    logic [WIDTH-1:0]      load_val = '0;
    logic [WIDTH-1:0]      limit = '0;
    logic [PRESCALE_W-1:0] prescale = '0;
    logic                  dir_down = 1'b0;
    logic                  mode_wrap = 1'b0;
    logic                  evt_ready = 1'b0;
    logic [WIDTH-1:0]      count;
    logic                  busy;
    logic                  done;
    logic                  evt_valid;
    logic                  overrun;
    logic [WIDTH+3:0]      obs;

    int n_cmp = 0;
    int n_err = 0;
    logic [WIDTH-1:0] exp_q[$];

    // reference model: state 0=idle 1=run 2=done, m_wait counts down to a step
    int m_st, m_cnt, m_wait, m_load, m_lim, m_ps, m_dn, m_wr, m_ev, m_ov;

    always #5 clk = ~clk;

    count_sequencer #(.WIDTH(WIDTH), .PRESCALE_W(PRESCALE_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .load_val  (load_val),
        .limit     (limit),
        .prescale  (prescale),
        .dir_down  (dir_down),
        .mode_wrap (mode_wrap),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .overrun   (overrun)
    );

    assign obs = {count, busy, done, evt_valid, overrun};

    function automatic logic [WIDTH+3:0] exp_vec();
        return {WIDTH'(m_cnt), m_st == 1, m_st == 2, m_ev != 0, m_ov != 0};
    endfunction

    task automatic model_reset();
        m_st = 0; m_cnt = 0; m_wait = 0; m_load = 0; m_lim = 0;
        m_ps = 0; m_dn = 0; m_wr = 0; m_ev = 0; m_ov = 0;
    endtask

    task automatic model_step();
        int nxt;
        int ev_next;
        ev_next = (m_ev != 0 && !evt_ready) ? 1 : 0;
        if (m_st == 1) begin
            if (stop) begin
                m_st = 0;
            end else if (m_wait > 0) begin
                m_wait = m_wait - 1;
            end else begin
                m_wait = m_ps;
                nxt = (m_dn != 0) ? (m_cnt + M - 1) % M : (m_cnt + 1) % M;
                if (nxt == m_lim) begin
                    if (m_ev != 0 && !evt_ready) m_ov = 1;
                    ev_next = 1;
                    if (m_wr != 0) begin
                        m_cnt = m_load;
                    end else begin
                        m_cnt = m_lim;
                        m_st = 2;
                    end
                end else begin
                    m_cnt = nxt;
                end
            end
        end else begin
            if (stop) begin
                m_st = 0;
            end else if (start) begin
                m_st = 1;
                m_cnt = int'(load_val); m_load = int'(load_val);
                m_lim = int'(limit); m_ps = int'(prescale); m_wait = int'(prescale);
                m_dn = int'(dir_down); m_wr = int'(mode_wrap);
                m_ov = 0;
            end
        end
        m_ev = ev_next;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic configure(input int lv, input int lim, input int ps, input int dn, input int wr);
        load_val = WIDTH'(lv); limit = WIDTH'(lim); prescale = PRESCALE_W'(ps);
        dir_down = (dn != 0); mode_wrap = (wr != 0);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        n_cmp++;
        if (obs !== '0) begin
            n_err++; $display("FAIL reset_outputs: got %h want %h", obs, {(WIDTH+4){1'b0}});
        end
        reset = 1'b1;
        tick();
        n_cmp++;
        if (obs !== exp_vec()) begin
            n_err++; $display("FAIL reset_release: got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_up_stop();
        configure(0, 3, 0, 0, 0);
        exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
        start = 1'b1;
        tick();
        start = 1'b0;
        while (exp_q.size() > 0) begin
            logic [WIDTH-1:0] e;
            e = exp_q.pop_front();
            n_cmp++;
            if (count !== e) begin
                n_err++; $display("FAIL up_count: got %0d want %0d", count, e);
            end
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_err++; $display("FAIL up_model: got %h want %h", obs, exp_vec());
            end
            if (exp_q.size() > 0) tick();
        end
        n_cmp++;
        if (obs !== {2'd3, 1'b0, 1'b1, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL up_done: got %h want %h", obs, {2'd3, 4'b0110});
        end
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        n_cmp++;
        if (obs !== {2'd3, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL up_accept: got %h want %h", obs, {2'd3, 4'b0100});
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_cmp++;
        if (obs !== exp_vec() || dut.state !== ST_IDLE) begin
            n_err++; $display("FAIL up_stop_idle: got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_down_prescale();
        configure(1, 3, 2, 1, 0);
        exp_q = '{2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd3};
        start = 1'b1;
        tick();
        start = 1'b0;
        while (exp_q.size() > 0) begin
            logic [WIDTH-1:0] e;
            e = exp_q.pop_front();
            n_cmp++;
            if (count !== e || obs !== exp_vec()) begin
                n_err++; $display("FAIL down_seq: got %h (count %0d) want %h (count %0d)", obs, count, exp_vec(), e);
            end
            if (exp_q.size() > 0) tick();
        end
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0 || evt_valid !== 1'b1) begin
            n_err++; $display("FAIL down_done: got busy/done/evt %b%b%b want 011", busy, done, evt_valid);
        end
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_cmp++;
        if (obs !== exp_vec()) begin
            n_err++; $display("FAIL down_stop: got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_wrap_ready();
        configure(0, 2, 0, 0, 1);
        evt_ready = 1'b1;
        exp_q = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0};
        start = 1'b1;
        tick();
        start = 1'b0;
        while (exp_q.size() > 0) begin
            logic [WIDTH-1:0] e;
            e = exp_q.pop_front();
            n_cmp++;
            if (count !== e || overrun !== 1'b0 || obs !== exp_vec()) begin
                n_err++; $display("FAIL wrap_ready: got %h (count %0d) want %h (count %0d)", obs, count, exp_vec(), e);
            end
            if (exp_q.size() > 0) tick();
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
        evt_ready = 1'b0;
        n_cmp++;
        if (obs !== exp_vec()) begin
            n_err++; $display("FAIL wrap_ready_stop: got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_wrap_overrun();
        configure(0, 2, 0, 0, 1);
        evt_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (obs !== {2'd0, 1'b1, 1'b0, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL ovr_first: got %h want %h", obs, {2'd0, 4'b1010});
        end
        tick();
        tick();
        n_cmp++;
        if (obs !== {2'd0, 1'b1, 1'b0, 1'b1, 1'b1}) begin
            n_err++; $display("FAIL ovr_second: got %h want %h", obs, {2'd0, 4'b1011});
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        n_cmp++;
        if (obs !== {2'd0, 1'b0, 1'b0, 1'b0, 1'b1} || obs !== exp_vec()) begin
            n_err++; $display("FAIL ovr_sticky: got %h want %h", obs, {2'd0, 4'b0001});
        end
        configure(1, 3, 0, 0, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++;
        if (overrun !== 1'b0 || obs !== exp_vec()) begin
            n_err++; $display("FAIL ovr_clear_on_start: got %h want %h", obs, exp_vec());
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic test_stop_start();
        configure(0, 3, 0, 0, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        start = 1'b0;
        n_cmp++;
        if (obs !== {2'd1, 1'b0, 1'b0, 1'b0, 1'b0} || dut.state !== ST_IDLE) begin
            n_err++; $display("FAIL stop_wins: got %h want %h", obs, {2'd1, 4'b0000});
        end
        configure(2, 0, 1, 0, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++;
        if (obs !== {2'd2, 1'b1, 1'b0, 1'b0, 1'b0} || obs !== exp_vec()) begin
            n_err++; $display("FAIL restart_load: got %h want %h", obs, {2'd2, 4'b1000});
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic test_async_reset();
        configure(0, 3, 0, 0, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (count !== 2'd2) begin
            n_err++; $display("FAIL async_pre: got count %0d want 2", count);
        end
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (obs !== '0 || dut.state !== ST_IDLE) begin
            n_err++; $display("FAIL async_reset: got %h want %h", obs, {(WIDTH+4){1'b0}});
        end
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        tick();
        n_cmp++;
        if (obs !== exp_vec()) begin
            n_err++; $display("FAIL async_release: got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            start = ($urandom_range(0, 11) == 0);
            stop = ($urandom_range(0, 39) == 0);
            evt_ready = ($urandom_range(0, 2) == 0);
            configure($urandom_range(0, M - 1), $urandom_range(0, M - 1),
                      $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1));
            tick();
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_err++; $display("FAIL random_cycle_%0d: got %h want %h", i, obs, exp_vec());
            end
        end
        start = 1'b0;
        stop = 1'b0;
        evt_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_up_stop();
        test_down_prescale();
        test_wrap_ready();
        test_wrap_overrun();
        test_stop_start();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
